mantissa_normalizer: RTL and testbench
======================================

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 flush_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  sum_mant is valid this cycle.
REQ-005 in_ready  output  1  block can accept a new sum_mant.
REQ-006 sum_mant  input  25  raw adder result; [24] = carry-out, [23:0] = unnormalized mantissa.
REQ-007 out_valid  output  1  result outputs valid.
REQ-008 out_ready  input  1  downstream exponent incrementer consumes the result.
REQ-009 norm_mant  output  24  normalized mantissa; [23] = hidden bit.
REQ-010 shift_amt  output  5  normalization distance; drives the incrementer's increment_value.
REQ-011 exp_adjust_en  output  1  exponent must change; drives the incrementer's enable.
REQ-012 exp_dec  output  1  0 = increment exponent by 1, 1 = decrement by shift_amt; drives increment_mode.
REQ-013 sticky  output  1  OR of bits shifted out on right shift.
REQ-014 is_zero  output  1  sum_mant was all zeros.

Function
REQ-015 The FSM SHALL have states IDLE, EVAL, DONE.
REQ-016 in_ready SHALL equal (state == IDLE), decoded from the state register.
REQ-017 In IDLE, in_valid=1 SHALL latch sum_mant into a 25-bit work register, clear the shift counter, and go to EVAL; in_valid=0 SHALL leave state unchanged.
REQ-018 In EVAL, work[24]=1 (carry) SHALL: norm_mant = work[24:1], shift_amt = 1, exp_adjust_en = 1, exp_dec = 0, sticky = work[0], is_zero = 0; go to DONE.
REQ-019 In EVAL, work[24]=0 and work[23]=1 SHALL: norm_mant = work[23:0], shift_amt = counter, exp_adjust_en = (counter != 0), exp_dec = (counter != 0), sticky = 0, is_zero = 0; go to DONE.
REQ-020 In EVAL, work[24:0]=0 SHALL: norm_mant = 0, shift_amt = 0, exp_adjust_en = 0, exp_dec = 0, sticky = 0, is_zero = 1; go to DONE.
REQ-021 In EVAL, otherwise, work[23:0] SHALL shift left by 1 (zero fill), the counter SHALL increment by 1, and the state SHALL remain EVAL.
REQ-022 The counter SHALL never exceed 23; maximum EVAL dwell is 24 cycles.
REQ-023 Latency SHALL be N+1 rising edges from the accepting edge to out_valid=1, where N is the leading-zero count of sum_mant[23:0] (N=0 for carry, zero, or bit23 set).
REQ-024 out_valid SHALL be 1 exactly while state == DONE.
REQ-025 In DONE, out_ready=1 SHALL return to IDLE at the next edge; out_ready=0 SHALL hold DONE.
REQ-026 All result outputs SHALL be registers, stable from the entry to DONE until the edge leaving DONE.
REQ-027 in_valid and sum_mant SHALL be ignored in EVAL and DONE (no accept, no corruption).
REQ-028 Result outputs SHALL retain their last values in IDLE and EVAL; only out_valid qualifies them.

Reset
REQ-029 flush_n=0 SHALL immediately force state IDLE, work register and counter to 0, and out_valid, norm_mant, shift_amt, exp_adjust_en, exp_dec, sticky, is_zero to 0, independent of clk.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted in EVAL or DONE SHALL discard the operation; no out_valid SHALL follow for it after release.
REQ-032 The first accept after flush_n rises SHALL occur no earlier than the first rising clk edge with flush_n=1.

Verification
REQ-033 sum_mant=25'h1000001, out_ready=1 -> one cycle: norm_mant=24'h800000, shift_amt=1, exp_adjust_en=1, exp_dec=0, sticky=1.
REQ-034 sum_mant=25'h0800000 -> out_valid 1 edge after accept: norm_mant=24'h800000, shift_amt=0, exp_adjust_en=0, exp_dec=0.
REQ-035 sum_mant=25'h0000001 -> out_valid 24 edges after accept: norm_mant=24'h800000, shift_amt=23, exp_adjust_en=1, exp_dec=1; in_ready=0 throughout.
REQ-036 sum_mant=0 -> is_zero=1, norm_mant=0, exp_adjust_en=0, latency 1.
REQ-037 sum_mant=25'h0012345, out_ready held 0 for 5 cycles -> outputs stable (norm_mant=24'h91A280, shift_amt=7), in_ready=0, new in_valid ignored; IDLE one edge after out_ready=1.
REQ-038 flush_n pulsed low mid-EVAL on 25'h0000001 -> all outputs 0 immediately, in_ready=1, no out_valid afterward.

Source files
------------

// File: rtl/mantissa_normalizer.sv
// Post-add mantissa normalizer: corrects carry-out with a one-bit right shift,
// or left-shifts one bit per cycle until the hidden bit is set.
module mantissa_normalizer (
   input  logic        clk,
   input  logic        flush_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] sum_mant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] norm_mant,
   output logic [4:0]  shift_amt,
   output logic        exp_adjust_en,
   output logic        exp_dec,
   output logic        sticky,
   output logic        is_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [24:0] r_work;
   logic [4:0]  r_cnt;
   logic [23:0] r_norm_mant;
   logic [4:0]  r_shift_amt;
   logic        r_exp_adjust_en;
   logic        r_exp_dec;
   logic        r_sticky;
   logic        r_is_zero;

   logic        w_carry;
   logic        w_hidden;
   logic        w_zero;
   logic        w_cnt_nz;

   assign w_carry  = r_work[24];
   assign w_hidden = r_work[23];
   assign w_zero   = (r_work == '0);
   assign w_cnt_nz = (r_cnt != '0);

   always_ff @(posedge clk or negedge flush_n) begin
      if (!flush_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (in_valid) w_next = EVAL;
         EVAL: if (w_carry || w_hidden || w_zero) w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A nonzero operand always reaches bit 23 within 23 shifts, so r_cnt stays <= 23.
   always_ff @(posedge clk or negedge flush_n) begin
      if (!flush_n) begin
         r_work          <= '0;
         r_cnt           <= '0;
         r_norm_mant     <= '0;
         r_shift_amt     <= '0;
         r_exp_adjust_en <= 1'b0;
         r_exp_dec       <= 1'b0;
         r_sticky        <= 1'b0;
         r_is_zero       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work <= sum_mant;
                  r_cnt  <= '0;
               end
            end
            EVAL: begin
               if (w_carry) begin
                  r_norm_mant     <= r_work[24:1];
                  r_shift_amt     <= 5'd1;
                  r_exp_adjust_en <= 1'b1;
                  r_exp_dec       <= 1'b0;
                  r_sticky        <= r_work[0];
                  r_is_zero       <= 1'b0;
               end else if (w_hidden) begin
                  r_norm_mant     <= r_work[23:0];
                  r_shift_amt     <= r_cnt;
                  r_exp_adjust_en <= w_cnt_nz;
                  r_exp_dec       <= w_cnt_nz;
                  r_sticky        <= 1'b0;
                  r_is_zero       <= 1'b0;
               end else if (w_zero) begin
                  r_norm_mant     <= '0;
                  r_shift_amt     <= '0;
                  r_exp_adjust_en <= 1'b0;
                  r_exp_dec       <= 1'b0;
                  r_sticky        <= 1'b0;
                  r_is_zero       <= 1'b1;
               end else begin
                  r_work <= {1'b0, r_work[22:0], 1'b0};
                  r_cnt  <= r_cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = (r_state == IDLE);
   assign out_valid     = (r_state == DONE);
   assign norm_mant     = r_norm_mant;
   assign shift_amt     = r_shift_amt;
   assign exp_adjust_en = r_exp_adjust_en;
   assign exp_dec       = r_exp_dec;
   assign sticky        = r_sticky;
   assign is_zero       = r_is_zero;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed and random checks of mantissa_normalizer against an arithmetic
// reference model (leading-zero count and shift computed directly).
module tb_mantissa_normalizer;

   logic        clk = 1'b0;
   logic        flush_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] sum_mant;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] norm_mant;
   logic [4:0]  shift_amt;
   logic        exp_adjust_en;
   logic        exp_dec;
   logic        sticky;
   logic        is_zero;

   int tests = 0;
   int fails = 0;

   mantissa_normalizer dut (
      .clk           (clk),
      .flush_n       (flush_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .sum_mant      (sum_mant),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .norm_mant     (norm_mant),
      .shift_amt     (shift_amt),
      .exp_adjust_en (exp_adjust_en),
      .exp_dec       (exp_dec),
      .sticky        (sticky),
      .is_zero       (is_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exponent adjustment is determined by where the leading one sits.
   task automatic model(input logic [24:0] s, output logic [23:0] m, output int sh,
                        output logic en, output logic dec, output logic st,
                        output logic z, output int lat);
      int n;
      logic [23:0] low;
      low = s[23:0];
      if (s[24]) begin
         m = s[24:1]; sh = 1; en = 1'b1; dec = 1'b0; st = s[0]; z = 1'b0; lat = 1;
      end else if (s == 25'd0) begin
         m = '0; sh = 0; en = 1'b0; dec = 1'b0; st = 1'b0; z = 1'b1; lat = 1;
      end else begin
         n = 0;
         while (low < 24'h800000) begin
            low = low * 2;
            n++;
         end
         m = low; sh = n; en = (n != 0); dec = (n != 0); st = 1'b0; z = 1'b0; lat = n + 1;
      end
   endtask

   task automatic run_op(input logic [24:0] s, input int hold);
      logic [23:0] em;
      int esh, elat, lat;
      logic een, edec, est, ez;
      model(s, em, esh, een, edec, est, ez, elat);
      @(negedge clk);
      check("ready_before", {31'd0, in_ready}, 32'd1);
      sum_mant = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < 40) begin
         check("ready_busy", {31'd0, in_ready}, 32'd0);
         sum_mant = 25'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, elat);
      check("norm_mant", {8'd0, norm_mant}, {8'd0, em});
      check("shift_amt", {27'd0, shift_amt}, esh);
      check("exp_adjust_en", {31'd0, exp_adjust_en}, {31'd0, een});
      check("exp_dec", {31'd0, exp_dec}, {31'd0, edec});
      check("sticky", {31'd0, sticky}, {31'd0, est});
      check("is_zero", {31'd0, is_zero}, {31'd0, ez});
      for (int k = 0; k < hold; k++) begin
         sum_mant = 25'($urandom);
         @(posedge clk); #1;
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_ready", {31'd0, in_ready}, 32'd0);
         check("hold_norm", {8'd0, norm_mant}, {8'd0, em});
         check("hold_shift", {27'd0, shift_amt}, esh);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [24:0] s;
      int cls, pos, seen;
      flush_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_mant = '0;
      #3;
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_norm", {8'd0, norm_mant}, 32'd0);
      repeat (2) @(negedge clk);
      flush_n = 1'b1;

      run_op(25'h1000001, 0);
      run_op(25'h0800000, 0);
      run_op(25'h0000001, 0);
      run_op(25'h0000000, 0);
      run_op(25'h0012345, 5);
      run_op(25'h1FFFFFE, 1);

      // Leave nonzero results behind, then flush mid-EVAL on the longest operand.
      run_op(25'h1FFFFFF, 0);
      @(negedge clk);
      sum_mant = 25'h0000001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 flush_n = 1'b0;
      #1;
      check("flush_ready", {31'd0, in_ready}, 32'd1);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_norm", {8'd0, norm_mant}, 32'd0);
      check("flush_shift", {27'd0, shift_amt}, 32'd0);
      check("flush_flags", {28'd0, exp_adjust_en, exp_dec, sticky, is_zero}, 32'd0);
      @(negedge clk);
      flush_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("flush_no_valid", seen, 0);

      for (int t = 0; t < 40; t++) begin
         cls = int'($urandom_range(0, 3));
         case (cls)
            0: s = {1'b1, 24'($urandom)};
            1: s = '0;
            2: begin
               pos = int'($urandom_range(0, 23));
               s = {1'b0, 24'($urandom)};
               s = s & ((25'd1 << pos) - 25'd1);
               s = s | (25'd1 << pos);
            end
            default: s = {1'b0, 24'($urandom)};
         endcase
         run_op(s, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
